// File: rtl/dac_channel_gen2_pkg.sv
// Shared types and arithmetic helpers for the gen2 DAC channel.
// The helpers work on 64-bit signed values, and the callers narrow the results to the width they need.
package dac_gen2_pkg;

    typedef enum logic [2:0] {
        SPI_IDLE,
        SPI_LEAD,
        SPI_SHIFT_HI,
        SPI_SHIFT_LO,
        SPI_TRAIL
    } spi_state_e;

    localparam int unsigned PD_W = 2;
    localparam logic [PD_W-1:0] PD_BITS = 2'b00;
    localparam int unsigned FRAME_BITS = 6 + PD_W + 16;

    function automatic int unsigned frame_bits(input int unsigned lead, input int unsigned dw);
        return lead + PD_W + dw;
    endfunction

    function automatic logic [63:0] midscale(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

    // Clamp v to the signed range of a w-bit word.
    function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int unsigned w);
        logic signed [63:0] mx;
        logic signed [63:0] mn;
        mx = (64'sd1 <<< (w - 1)) - 64'sd1;
        mn = -(64'sd1 <<< (w - 1));
        if (v > mx) return mx;
        if (v < mn) return mn;
        return v;
    endfunction

    function automatic logic signed [63:0] sat_shl(input logic signed [63:0] v, input logic [2:0] sh,
                                                   input int unsigned w);
        return sat_s(v <<< sh, w);
    endfunction

endpackage

// File: rtl/dac_channel_gen2_if.sv
// Sample, control, status and SPI signals of one gen2 DAC channel.
interface dac_channel_gen2_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned COEF_W = 16
);
    logic              sample_valid;
    logic [DATA_W-1:0] sample_in;
    logic [DATA_W-1:0] seq_in;
    logic              use_sequencer;
    logic              dac_en;
    logic              hpf_en;
    logic [COEF_W-1:0] hpf_coef;
    logic [2:0]        gain;
    logic [6:0]        noise_suppress;
    logic [DATA_W-1:0] thrsh;
    logic [DATA_W-1:0] thrsh_hyst;
    logic              thrsh_pol;
    logic [DATA_W-1:0] dac_register;
    logic              thrsh_out;
    logic              busy;
    logic              frame_done;
    logic              overrun;
    logic              dac_sync;
    logic              dac_sclk;
    logic              dac_din;

    modport master (
        output sample_valid, sample_in, seq_in, use_sequencer, dac_en, hpf_en, hpf_coef,
               gain, noise_suppress, thrsh, thrsh_hyst, thrsh_pol,
        input  dac_register, thrsh_out, busy, frame_done, overrun, dac_sync, dac_sclk, dac_din
    );

    modport slave (
        input  sample_valid, sample_in, seq_in, use_sequencer, dac_en, hpf_en, hpf_coef,
               gain, noise_suppress, thrsh, thrsh_hyst, thrsh_pol,
        output dac_register, thrsh_out, busy, frame_done, overrun, dac_sync, dac_sclk, dac_din
    );
endinterface

// File: rtl/dac_spi_serializer.sv
// AD5662 frame serializer with an internal SCLK divider.
// It also holds a one-deep pending request, and the newest word wins.
module dac_spi_serializer
    import dac_gen2_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned SCLK_DIV   = 2,
    parameter int unsigned LEAD_ZEROS = 6
) (
    input  logic              dataclk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] word,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun,
    output logic              dac_sync,
    output logic              dac_sclk,
    output logic              dac_din
);
    localparam int unsigned FB    = frame_bits(LEAD_ZEROS, DATA_W);
    localparam int unsigned DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(FB);

    spi_state_e       state;
    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [FB-1:0]    shreg;
    logic             pending;
    logic             phase_end;

    assign phase_end = (div_cnt == DIV_W'(SCLK_DIV - 1));

    always_ff @(posedge dataclk or posedge reset) begin
        if (reset) begin
            state      <= SPI_IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            pending    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            dac_sync   <= 1'b1;
            dac_sclk   <= 1'b0;
            dac_din    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            if (state != SPI_IDLE) begin
                div_cnt <= phase_end ? '0 : div_cnt + DIV_W'(1);
                // A result that arrives during a frame waits; a second one replaces it.
                if (start) begin
                    if (pending) overrun <= 1'b1;
                    else         pending <= 1'b1;
                end
            end
            case (state)
                SPI_IDLE: begin
                    if (start || pending) begin
                        state    <= SPI_LEAD;
                        busy     <= 1'b1;
                        dac_sync <= 1'b0;
                        dac_sclk <= 1'b0;
                        dac_din  <= 1'b0;
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        shreg    <= FB'({PD_BITS, word});
                        pending  <= 1'b0;
                    end
                end
                SPI_LEAD: begin
                    if (phase_end) begin
                        state    <= SPI_SHIFT_HI;
                        dac_sclk <= 1'b1;
                        dac_din  <= shreg[FB-1];
                        shreg    <= {shreg[FB-2:0], 1'b0};
                    end
                end
                SPI_SHIFT_HI: begin
                    if (phase_end) begin
                        state    <= SPI_SHIFT_LO;
                        dac_sclk <= 1'b0;
                    end
                end
                SPI_SHIFT_LO: begin
                    if (phase_end) begin
                        if (bit_cnt == BIT_W'(FB - 1)) begin
                            state    <= SPI_TRAIL;
                            dac_sync <= 1'b1;
                            dac_din  <= 1'b0;
                        end else begin
                            bit_cnt  <= bit_cnt + BIT_W'(1);
                            state    <= SPI_SHIFT_HI;
                            dac_sclk <= 1'b1;
                            dac_din  <= shreg[FB-1];
                            shreg    <= {shreg[FB-2:0], 1'b0};
                        end
                    end
                end
                SPI_TRAIL: begin
                    if (phase_end) begin
                        state      <= SPI_IDLE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= SPI_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/dac_channel_gen2.sv
// Per-channel DAC path: it takes an offset-binary sample through an optional HPF, a deadband, gain and a
// hysteresis comparator, and then sends the result as an AD5662 SPI frame.
module dac_channel_gen2
    import dac_gen2_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned COEF_W     = 16,
    parameter int unsigned STATE_FRAC = 14,
    parameter int unsigned SCLK_DIV   = 2,
    parameter int unsigned LEAD_ZEROS = 6
) (
    input logic               dataclk,
    input logic               reset,
    dac_channel_gen2_if.slave bus
);
    localparam int unsigned SW = DATA_W + STATE_FRAC;
    localparam logic [DATA_W-1:0] MID = DATA_W'(midscale(DATA_W));

    logic                     s1_valid, s2_valid, s3_valid;
    logic signed [DATA_W-1:0] s1_x, s2_y, st_top, diff, y_nxt;
    logic signed [SW-1:0]     hpf_state;
    logic signed [63:0]       diff64, inc64, state_nxt64, y64, ns64, ns_y, g64;
    logic [DATA_W-1:0]        y_ob, lo, hi, scaled, dac_reg_q;
    logic [DATA_W:0]          hi_sum;
    logic                     thr_nxt, thrsh_q;
    logic                     unused_hi;

    // The high-pass output is the input minus a leaky integrator of the output.
    always_comb begin
        st_top      = hpf_state[SW-1 -: DATA_W];
        diff64      = sat_s(64'(s1_x) - 64'(st_top), DATA_W);
        diff        = DATA_W'(diff64);
        inc64       = (diff64 * $signed(64'(bus.hpf_coef))) >>> (COEF_W - STATE_FRAC);
        state_nxt64 = sat_s(64'(hpf_state) + inc64, SW);
        y_nxt       = bus.hpf_en ? diff : s1_x;
    end

    // These are the deadband, gain and comparator. The comparator uses y before the deadband and gain.
    always_comb begin
        y64  = 64'(s2_y);
        ns64 = $signed(64'(bus.noise_suppress)) <<< (DATA_W - 12);
        if (y64 > ns64)       ns_y = y64 - ns64;
        else if (y64 < -ns64) ns_y = y64 + ns64;
        else                  ns_y = '0;
        g64    = sat_shl(ns_y, bus.gain, DATA_W);
        scaled = DATA_W'(g64) ^ MID;
        y_ob   = {~s2_y[DATA_W-1], s2_y[DATA_W-2:0]};
        lo     = (bus.thrsh >= bus.thrsh_hyst) ? bus.thrsh - bus.thrsh_hyst : '0;
        hi_sum = {1'b0, bus.thrsh} + {1'b0, bus.thrsh_hyst};
        hi     = hi_sum[DATA_W] ? '1 : hi_sum[DATA_W-1:0];
        thr_nxt = thrsh_q;
        if (bus.thrsh_pol) begin
            if (y_ob >= bus.thrsh) thr_nxt = 1'b1;
            else if (y_ob < lo)    thr_nxt = 1'b0;
        end else begin
            if (y_ob <= bus.thrsh) thr_nxt = 1'b1;
            else if (y_ob > hi)    thr_nxt = 1'b0;
        end
    end

    // After saturation the bits above the narrowed width only hold copies of the sign.
    assign unused_hi = ^{state_nxt64[63:SW], g64[63:DATA_W]};

    always_ff @(posedge dataclk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s3_valid  <= 1'b0;
            s1_x      <= '0;
            s2_y      <= '0;
            hpf_state <= '0;
            dac_reg_q <= MID;
            thrsh_q   <= 1'b0;
        end else begin
            s1_valid <= bus.sample_valid;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
            if (bus.sample_valid) s1_x <= {~bus.sample_in[DATA_W-1], bus.sample_in[DATA_W-2:0]};
            if (s1_valid) s2_y <= y_nxt;
            if (!bus.hpf_en)   hpf_state <= '0;
            else if (s1_valid) hpf_state <= SW'(state_nxt64);
            if (s2_valid) begin
                dac_reg_q <= bus.use_sequencer ? bus.seq_in : (bus.dac_en ? scaled : MID);
            end
            if (!bus.dac_en)   thrsh_q <= 1'b0;
            else if (s2_valid) thrsh_q <= thr_nxt;
        end
    end

    assign bus.dac_register = dac_reg_q;
    assign bus.thrsh_out    = thrsh_q;

    dac_spi_serializer #(
        .DATA_W    (DATA_W),
        .SCLK_DIV  (SCLK_DIV),
        .LEAD_ZEROS(LEAD_ZEROS)
    ) u_ser (
        .dataclk   (dataclk),
        .reset     (reset),
        .start     (s3_valid),
        .word      (dac_reg_q),
        .busy      (bus.busy),
        .frame_done(bus.frame_done),
        .overrun   (bus.overrun),
        .dac_sync  (bus.dac_sync),
        .dac_sclk  (bus.dac_sclk),
        .dac_din   (bus.dac_din)
    );
endmodule

// File: tb/tb_dac_channel_gen2.sv
// Directed bench for dac_channel_gen2: a table of datapath vectors, then frame, overrun and reset sequences.
module tb_dac_channel_gen2;
    logic dataclk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    dac_channel_gen2_if #(.DATA_W(16), .COEF_W(16)) bus ();

    dac_channel_gen2 dut (
        .dataclk(dataclk),
        .reset  (reset),
        .bus    (bus)
    );

    initial dataclk = 1'b0;
    always #5 dataclk = ~dataclk;

    typedef struct {
        logic [15:0] sample;
        logic        hpf_en;
        logic [15:0] coef;
        logic [2:0]  gain;
        logic [6:0]  ns;
        logic        dac_en;
        logic        use_seq;
        logic [15:0] seq;
        logic [15:0] thr;
        logic [15:0] hyst;
        logic        pol;
        logic [15:0] exp_dac;
        logic        exp_thr;
    } vec_t;

    vec_t vecs[22];

    function automatic vec_t mk(input logic [15:0] sample, input logic hpf_en, input logic [15:0] coef,
                                input logic [2:0] gain, input logic [6:0] ns, input logic dac_en,
                                input logic use_seq, input logic [15:0] seq, input logic [15:0] thr,
                                input logic [15:0] hyst, input logic pol, input logic [15:0] exp_dac,
                                input logic exp_thr);
        vec_t v;
        v.sample = sample; v.hpf_en = hpf_en; v.coef = coef; v.gain = gain; v.ns = ns;
        v.dac_en = dac_en; v.use_seq = use_seq; v.seq = seq; v.thr = thr; v.hyst = hyst;
        v.pol = pol; v.exp_dac = exp_dac; v.exp_thr = exp_thr;
        return v;
    endfunction

    // Frame monitor, sampled on the falling dataclk edge
    int          busy_n, sync_lo_n, done_n, ovr_n, fall_n, done_bad;
    logic        prev_sclk, prev_busy;
    logic [23:0] sh;
    logic [23:0] frames[$];

    always @(negedge dataclk) begin
        if (bus.busy) busy_n++;
        if (!bus.dac_sync) sync_lo_n++;
        if (bus.overrun) ovr_n++;
        if (prev_sclk && !bus.dac_sclk) begin
            sh = {sh[22:0], bus.dac_din};
            fall_n++;
        end
        if (bus.frame_done) begin
            done_n++;
            frames.push_back(sh);
            if (!(prev_busy && !bus.busy)) done_bad++;
        end
        prev_sclk = bus.dac_sclk;
        prev_busy = bus.busy;
    end

    task automatic clear_mon();
        busy_n = 0; sync_lo_n = 0; done_n = 0; ovr_n = 0; fall_n = 0; done_bad = 0;
        prev_sclk = 1'b0; prev_busy = 1'b0; sh = '0;
        frames.delete();
    endtask

    task automatic tick();
        @(posedge dataclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] frame_at(input int idx);
        if (frames.size() > idx) return frames[idx];
        return 24'hxxxxxx;
    endfunction

    task automatic set_pass();
        bus.hpf_en = 1'b0; bus.hpf_coef = '0; bus.gain = '0; bus.noise_suppress = '0;
        bus.dac_en = 1'b1; bus.use_sequencer = 1'b0; bus.seq_in = '0;
        bus.thrsh = 16'hFFFF; bus.thrsh_hyst = '0; bus.thrsh_pol = 1'b1;
    endtask

    task automatic strobe(input logic [15:0] s);
        bus.sample_in = s;
        bus.sample_valid = 1'b1;
        tick();
        bus.sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before the end of the test");
        $fatal(1, "watchdog");
    end

    initial begin
        //                sample    hpf coef     g  ns en sq seq       thr       hyst      pol exp_dac   thr
        vecs[0]  = mk(16'hC000, 0, 16'h0000, 0, 0, 1, 0, 16'h0000, 16'hFFFF, 16'h0000, 1, 16'hC000, 0);
        vecs[1]  = mk(16'h8010, 0, 16'h0000, 0, 2, 1, 0, 16'h0000, 16'hFFFF, 16'h0000, 1, 16'h8000, 0);
        vecs[2]  = mk(16'h8100, 0, 16'h0000, 0, 2, 1, 0, 16'h0000, 16'hFFFF, 16'h0000, 1, 16'h80E0, 0);
        vecs[3]  = mk(16'h7F00, 0, 16'h0000, 0, 2, 1, 0, 16'h0000, 16'hFFFF, 16'h0000, 1, 16'h7F20, 0);
        vecs[4]  = mk(16'hF000, 0, 16'h0000, 3, 0, 1, 0, 16'h0000, 16'hFFFF, 16'h0000, 1, 16'hFFFF, 0);
        vecs[5]  = mk(16'h1000, 0, 16'h0000, 3, 0, 1, 0, 16'h0000, 16'hFFFF, 16'h0000, 1, 16'h0000, 0);
        vecs[6]  = mk(16'h9000, 0, 16'h0000, 1, 0, 1, 0, 16'h0000, 16'hFFFF, 16'h0000, 1, 16'hA000, 0);
        vecs[7]  = mk(16'hC000, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'hFFFF, 16'h0000, 1, 16'h8000, 0);
        vecs[8]  = mk(16'hC000, 0, 16'h0000, 0, 0, 0, 1, 16'h1234, 16'hFFFF, 16'h0000, 1, 16'h1234, 0);
        vecs[9]  = mk(16'hA000, 1, 16'h8000, 0, 0, 1, 0, 16'h0000, 16'hFFFF, 16'h0000, 1, 16'hA000, 0);
        vecs[10] = mk(16'hA000, 1, 16'h8000, 0, 0, 1, 0, 16'h0000, 16'hFFFF, 16'h0000, 1, 16'h9000, 0);
        vecs[11] = mk(16'hA000, 1, 16'h8000, 0, 0, 1, 0, 16'h0000, 16'hFFFF, 16'h0000, 1, 16'h8800, 0);
        vecs[12] = mk(16'hA000, 1, 16'h8000, 0, 0, 1, 0, 16'h0000, 16'hFFFF, 16'h0000, 1, 16'h8400, 0);
        vecs[13] = mk(16'hA000, 0, 16'h8000, 0, 0, 1, 0, 16'h0000, 16'hFFFF, 16'h0000, 1, 16'hA000, 0);
        vecs[14] = mk(16'h9000, 0, 16'h0000, 0, 0, 1, 0, 16'h0000, 16'h9000, 16'h0100, 1, 16'h9000, 1);
        vecs[15] = mk(16'h8F80, 0, 16'h0000, 0, 0, 1, 0, 16'h0000, 16'h9000, 16'h0100, 1, 16'h8F80, 1);
        vecs[16] = mk(16'h8EFF, 0, 16'h0000, 0, 0, 1, 0, 16'h0000, 16'h9000, 16'h0100, 1, 16'h8EFF, 0);
        vecs[17] = mk(16'h9100, 0, 16'h0000, 0, 0, 1, 0, 16'h0000, 16'h9000, 16'h0100, 1, 16'h9100, 1);
        vecs[18] = mk(16'h9100, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h9000, 16'h0100, 1, 16'h8000, 0);
        vecs[19] = mk(16'h7000, 0, 16'h0000, 0, 0, 1, 0, 16'h0000, 16'h7000, 16'h0100, 0, 16'h7000, 1);
        vecs[20] = mk(16'h7080, 0, 16'h0000, 0, 0, 1, 0, 16'h0000, 16'h7000, 16'h0100, 0, 16'h7080, 1);
        vecs[21] = mk(16'h7101, 0, 16'h0000, 0, 0, 1, 0, 16'h0000, 16'h7000, 16'h0100, 0, 16'h7101, 0);

        reset = 1'b1;
        bus.sample_valid = 1'b0;
        bus.sample_in = '0;
        set_pass();
        clear_mon();
        repeat (3) tick();

        chk("rst_sync", 32'(bus.dac_sync), 32'd1);
        chk("rst_sclk", 32'(bus.dac_sclk), 32'd0);
        chk("rst_din", 32'(bus.dac_din), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.frame_done), 32'd0);
        chk("rst_overrun", 32'(bus.overrun), 32'd0);
        chk("rst_thrsh_out", 32'(bus.thrsh_out), 32'd0);
        chk("rst_dac_register", 32'(bus.dac_register), 32'h8000);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 22; i++) begin
            bus.hpf_en = vecs[i].hpf_en;   bus.hpf_coef = vecs[i].coef;
            bus.gain = vecs[i].gain;       bus.noise_suppress = vecs[i].ns;
            bus.dac_en = vecs[i].dac_en;   bus.use_sequencer = vecs[i].use_seq;
            bus.seq_in = vecs[i].seq;      bus.thrsh = vecs[i].thr;
            bus.thrsh_hyst = vecs[i].hyst; bus.thrsh_pol = vecs[i].pol;
            strobe(vecs[i].sample);
            tick();
            tick();
            chk($sformatf("vec%0d_dac", i), 32'(bus.dac_register), 32'(vecs[i].exp_dac));
            chk($sformatf("vec%0d_thr", i), 32'(bus.thrsh_out), 32'(vecs[i].exp_thr));
        end

        // The passthrough frame checks latency, frame contents and frame length.
        do_reset();
        set_pass();
        clear_mon();
        strobe(16'hC000);
        tick();
        chk("pass_dac_T2", 32'(bus.dac_register), 32'h8000);
        tick();
        chk("pass_dac_T3", 32'(bus.dac_register), 32'hC000);
        chk("pass_busy_T3", 32'(bus.busy), 32'd0);
        tick();
        chk("pass_busy_T4", 32'(bus.busy), 32'd1);
        repeat (130) tick();
        chk("pass_busy_cycles", 32'(busy_n), 32'd100);
        chk("pass_sync_low", 32'(sync_lo_n), 32'd98);
        chk("pass_done_pulses", 32'(done_n), 32'd1);
        chk("pass_done_align", 32'(done_bad), 32'd0);
        chk("pass_falls", 32'(fall_n), 32'd24);
        chk("pass_frame", 32'(frame_at(0)), 32'h00C000);

        // Strobes every 20 cycles: one frame is pending and the newest word wins.
        do_reset();
        set_pass();
        clear_mon();
        for (int c = 0; c < 300; c++) begin
            if ((c % 20 == 0) && (c < 100)) begin
                bus.sample_in = 16'(16'h9000 + 16'h1000 * (c / 20));
                bus.sample_valid = 1'b1;
            end else begin
                bus.sample_valid = 1'b0;
            end
            tick();
        end
        bus.sample_valid = 1'b0;
        chk("ovr_pulses", 32'(ovr_n), 32'd3);
        chk("ovr_done_pulses", 32'(done_n), 32'd2);
        chk("ovr_busy_cycles", 32'(busy_n), 32'd200);
        chk("ovr_done_align", 32'(done_bad), 32'd0);
        chk("ovr_frame0", 32'(frame_at(0)), 32'h009000);
        chk("ovr_frame1", 32'(frame_at(1)), 32'h00D000);

        // The sequencer word overrides dac_en = 0.
        clear_mon();
        bus.use_sequencer = 1'b1;
        bus.seq_in = 16'h1234;
        bus.dac_en = 1'b0;
        strobe(16'hC000);
        tick();
        tick();
        chk("seq_dac", 32'(bus.dac_register), 32'h1234);
        repeat (140) tick();
        chk("seq_done_pulses", 32'(done_n), 32'd1);
        chk("seq_frame", 32'(frame_at(0)), 32'h001234);

        // A reset in the middle of a frame aborts it, and no completion pulse follows.
        set_pass();
        strobe(16'hE000);
        repeat (30) tick();
        chk("mid_busy_pre", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_sync", 32'(bus.dac_sync), 32'd1);
        chk("mid_rst_sclk", 32'(bus.dac_sclk), 32'd0);
        chk("mid_rst_din", 32'(bus.dac_din), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_dac", 32'(bus.dac_register), 32'h8000);
        tick();
        tick();
        reset = 1'b0;
        clear_mon();
        repeat (150) tick();
        chk("mid_no_done", 32'(done_n), 32'd0);
        chk("mid_no_busy", 32'(busy_n), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
